// File: rtl/alu_multicycle.sv
// Registered RV32I/M-style ALU: logic, add/sub and compares finish in one cycle,
// shifts iterate one bit per cycle and MUL runs a WIDTH-step shift-add loop.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             v_q;
    logic             c_q;
    logic             n_q;
    logic             z_q;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic             is_shift_in;
    logic             iterative_in;
    logic             last_step;

    logic             sub_sel;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_result;
    logic             sc_v;
    logic             sc_c;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_result;

    // A new request is only taken when no iterative op is in flight.
    assign accept       = start && ((state == IDLE) || (state == DONE));
    assign shamt        = B[SHW-1:0];
    assign is_shift_in  = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                          (ALUControl == OP_SRA);
    assign iterative_in = (is_shift_in && (shamt != '0)) || (ALUControl == OP_MUL);
    assign last_step    = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = iterative_in ? RUN : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Single-cycle path works straight off the inputs; shifts report A so a
    // zero shift amount can complete without entering RUN.
    always_comb begin
        sub_sel   = (ALUControl == OP_SUB);
        b_eff     = sub_sel ? ~B : B;
        sum_ext   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
        sc_result = '0;
        sc_v      = 1'b0;
        sc_c      = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                sc_result = sum_ext[WIDTH-1:0];
                sc_c      = sum_ext[WIDTH];
                sc_v      = (A[WIDTH-1] ^ sum_ext[WIDTH-1]) &
                            ~(A[WIDTH-1] ^ B[WIDTH-1] ^ sub_sel);
            end
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_XOR:  sc_result = A ^ B;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL, OP_SRL, OP_SRA: sc_result = A;
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        step_a   = opa_q;
        step_b   = opb_q;
        step_acc = acc_q;
        case (op_q)
            OP_SLL: step_a = opa_q << 1;
            OP_SRL: step_a = opa_q >> 1;
            OP_SRA: step_a = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
            OP_MUL: begin
                step_acc = acc_q + (opb_q[0] ? opa_q : '0);
                step_a   = opa_q << 1;
                step_b   = opb_q >> 1;
            end
            default: ;
        endcase
        step_result = (op_q == OP_MUL) ? step_acc : step_a;
    end

    // Operands, loop state and the committed result/flags; flags only move on
    // the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else if (accept) begin
            op_q <= ALUControl;
            if (iterative_in) begin
                opa_q <= A;
                opb_q <= B;
                acc_q <= '0;
                cnt_q <= (ALUControl == OP_MUL) ? CW'(WIDTH) : {1'b0, shamt};
            end else begin
                result_q <= sc_result;
                v_q      <= sc_v;
                c_q      <= sc_c;
                n_q      <= sc_result[WIDTH-1];
                z_q      <= (sc_result == '0);
            end
        end else if (state == RUN) begin
            opa_q <= step_a;
            opb_q <= step_b;
            acc_q <= step_acc;
            cnt_q <= cnt_q - CW'(1);
            if (last_step) begin
                result_q <= step_result;
                v_q      <= 1'b0;
                c_q      <= 1'b0;
                n_q      <= step_result[WIDTH-1];
                z_q      <= (step_result == '0);
            end
        end
    end

    assign Result = result_q;
    assign V      = v_q;
    assign C      = c_q;
    assign N      = n_q;
    assign Z      = z_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, multi-cycle corner sequences
// and randomized ops on 32- and 16-bit instances against an arithmetic model.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [3:0]  ctl32 = '0;
    logic        busy32, done32, v32, c32, n32, z32;
    logic [31:0] res32;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [3:0]  ctl16 = '0;
    logic        busy16, done16, v16, c16, n16, z16;
    logic [15:0] res16;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  vcnz;
        int          lat;
        int          poke;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .ALUControl(ctl32),
        .busy(busy32), .done(done32), .Result(res32), .V(v32), .C(c32), .N(n32), .Z(z32)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .ALUControl(ctl16),
        .busy(busy16), .done(done16), .Result(res16), .V(v16), .C(c16), .N(n16), .Z(z16)
    );

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res,
                                input logic [3:0] vcnz, input int lat, input int poke);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.vcnz = vcnz; v.lat = lat; v.poke = poke;
        return v;
    endfunction

    // Reference: plain wide arithmetic at width w, latency from the op rules.
    function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a_in,
                                  input logic [31:0] b_in, output logic [31:0] res,
                                  output logic [3:0] vcnz, output int lat);
        longint unsigned mask, a, b, r;
        longint sa, sb, s, lim;
        int k;
        bit v, c;
        mask = (64'd1 << w) - 64'd1;
        a = {32'd0, a_in} & mask;
        b = {32'd0, b_in} & mask;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        lim = longint'(1) << (w - 1);
        k = int'(b % longint'(w));
        v = 0; c = 0; lat = 1; r = 0; s = 0;
        case (op)
            4'd0: begin r = a + b; c = r[w]; s = sa + sb; v = (s >= lim) || (s < -lim); end
            4'd1: begin r = a - b; c = (a >= b); s = sa - sb; v = (s >= lim) || (s < -lim); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd6: r = (a < b) ? 64'd1 : 64'd0;
            4'd7: begin r = a << k; lat = (k == 0) ? 1 : k + 1; end
            4'd8: begin r = a >> k; lat = (k == 0) ? 1 : k + 1; end
            4'd9: begin r = $unsigned(sa >>> k); lat = (k == 0) ? 1 : k + 1; end
            4'd10: begin r = a * b; lat = w + 1; end
            default: r = 0;
        endcase
        r = r & mask;
        res = r[31:0];
        vcnz = {v, c, r[w-1], (r == 0)};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit sel16, input bit st, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel16) begin
            start16 = st; ctl16 = op; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            start32 = st; ctl32 = op; a32 = a; b32 = b;
        end
    endtask

    function automatic bit dut_done(input bit sel16);
        return sel16 ? done16 : done32;
    endfunction

    function automatic bit dut_busy(input bit sel16);
        return sel16 ? busy16 : busy32;
    endfunction

    // Start one op, scramble inputs after the accept edge, optionally pulse
    // start during RUN, and count cycles until done.
    task automatic apply_stimulus(input bit sel16, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int poke,
                                  output logic [31:0] res, output logic [3:0] vcnz,
                                  output int lat, output int busy_cycles, output bit timed_out);
        @(negedge clk);
        drive(sel16, 1'b1, op, a, b);
        @(negedge clk);
        drive(sel16, 1'b0, 4'($urandom), $urandom, $urandom);
        lat = 1;
        busy_cycles = 0;
        while (!dut_done(sel16) && lat < 100) begin
            if (dut_busy(sel16)) busy_cycles++;
            drive(sel16, (lat == poke), 4'($urandom), $urandom, $urandom);
            @(negedge clk);
            lat++;
        end
        drive(sel16, 1'b0, 4'd0, 32'd0, 32'd0);
        timed_out = !dut_done(sel16);
        res  = sel16 ? {16'd0, res16} : res32;
        vcnz = sel16 ? {v16, c16, n16, z16} : {v32, c32, n32, z32};
    endtask

    task automatic run_and_check(input bit sel16, input string name, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input int poke,
                                 input logic [31:0] exp_res, input logic [3:0] exp_vcnz,
                                 input int exp_lat);
        logic [31:0] res;
        logic [3:0]  vcnz;
        int          lat, busy_cycles;
        bit          timed_out;
        apply_stimulus(sel16, op, a, b, poke, res, vcnz, lat, busy_cycles, timed_out);
        check_output({name, "_done_seen"}, {63'd0, !timed_out}, 64'd1);
        check_output({name, "_result"}, {32'd0, res}, {32'd0, exp_res});
        check_output({name, "_vcnz"}, {60'd0, vcnz}, {60'd0, exp_vcnz});
        check_output({name, "_latency"}, lat, exp_lat);
        check_output({name, "_busy_cycles"}, busy_cycles, exp_lat - 1);
        @(negedge clk);
        check_output({name, "_no_extra_done"}, {63'd0, dut_done(sel16)}, 64'd0);
    endtask

    initial begin
        logic [31:0] mres;
        logic [3:0]  mvcnz;
        int          mlat;
        int          seen;

        vecs[0]  = mk("add_ovf",   4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010, 1, 0);
        vecs[1]  = mk("sub_eq",    4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0101, 1, 0);
        vecs[2]  = mk("slt",       4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1, 0);
        vecs[3]  = mk("sltu",      4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0001, 1, 0);
        vecs[4]  = mk("sra4",      4'd9,  32'h80000000, 32'h00000004, 32'hF8000000, 4'b0010, 5, 2);
        vecs[5]  = mk("sll_b32",   4'd7,  32'h12345678, 32'h00000020, 32'h12345678, 4'b0000, 1, 0);
        vecs[6]  = mk("mul_ones",  4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33, 7);
        vecs[7]  = mk("mul_zero",  4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0001, 33, 0);
        vecs[8]  = mk("xor",       4'd4,  32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 4'b0000, 1, 0);
        vecs[9]  = mk("and",       4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1, 0);
        vecs[10] = mk("illegal",   4'd12, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 4'b0001, 1, 0);
        vecs[11] = mk("sub_borrow",4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0010, 1, 0);
        vecs[12] = mk("sub_ovf",   4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100, 1, 0);
        vecs[13] = mk("srl31",     4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 32, 30);
        vecs[14] = mk("or_zero",   4'd3,  32'h00000000, 32'h00000000, 32'h00000000, 4'b0001, 1, 0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {63'd0, busy32}, 64'd0);
        check_output("reset_done", {63'd0, done32}, 64'd0);
        check_output("reset_result", {32'd0, res32}, 64'd0);
        check_output("reset_flags", {60'd0, v32, c32, n32, z32}, 64'd0);
        check_output("reset_result16", {48'd0, res16}, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_and_check(1'b0, vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].poke,
                          vecs[i].res, vecs[i].vcnz, vecs[i].lat);
        end

        // Back-to-back: second start held high through the first DONE cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd0, 32'd1, 32'd2);
        @(negedge clk);
        check_output("b2b_first_done", {63'd0, done32}, 64'd1);
        check_output("b2b_first_result", {32'd0, res32}, 64'd3);
        drive(1'b0, 1'b1, 4'd4, 32'hF0F0F0F0, 32'hFFFF0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        check_output("b2b_second_done", {63'd0, done32}, 64'd1);
        check_output("b2b_second_result", {32'd0, res32}, 64'h0F0FF0F0);
        @(negedge clk);
        check_output("b2b_idle_after", {63'd0, done32}, 64'd0);

        // Reset in the middle of a MUL aborts with no done.
        drive(1'b0, 1'b1, 4'd10, 32'h00001234, 32'h00005678);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        check_output("mul_busy_before_rst", {63'd0, busy32}, 64'd1);
        rst = 1'b1;
        #1;
        check_output("rst_mid_busy", {63'd0, busy32}, 64'd0);
        check_output("rst_mid_done", {63'd0, done32}, 64'd0);
        check_output("rst_mid_result", {32'd0, res32}, 64'd0);
        check_output("rst_mid_flags", {60'd0, v32, c32, n32, z32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen++;
        end
        check_output("rst_mid_no_done", seen, 0);
        run_and_check(1'b0, "after_rst_add", 4'd0, 32'd3, 32'd4, 0, 32'd7, 4'b0000, 1);

        run_and_check(1'b1, "w16_mul", 4'd10, 32'h00FF, 32'h0101, 0, 32'hFFFF, 4'b0010, 17);
        run_and_check(1'b1, "w16_srl15", 4'd8, 32'h8000, 32'h000F, 3, 32'h0001, 4'b0000, 16);

        for (int i = 0; i < 120; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], 31'd0} | (a & 32'hFF);
            model(32, op, a, b, mres, mvcnz, mlat);
            run_and_check(1'b0, $sformatf("rand32_%0d", i), op, a, b,
                          int'($urandom_range(0, 4)), mres, mvcnz, mlat);
        end

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = {16'd0, 16'($urandom)};
            b = {16'd0, 16'($urandom)};
            model(16, op, a, b, mres, mvcnz, mlat);
            run_and_check(1'b1, $sformatf("rand16_%0d", i), op, a, b,
                          int'($urandom_range(0, 4)), mres, mvcnz, mlat);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
